sys_loader: RTL and testbench

Parametrised host-side loader for the NPU/CPU system top level. It accepts load commands and a valid/ready word stream, writes program words into the instruction ROM, and packs words into full-width lines for the NPU RAM's external write port. While a load is active it owns the NPU RAM selector and holds the CPU in its reset/hold mode. It replaces the statically tied external RAM inputs at the system top.

---
 rtl/sys_loader_pkg.sv | 22 ++
 rtl/sys_loader_line_packer.sv | 42 ++++
 rtl/sys_loader.sv | 148 ++++++++++++++
 tb/tb_sys_loader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_loader_pkg.sv
// Shared definitions for the host-side loader: FSM states, load targets and
// the words-per-line derivation.
package sys_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROM_WR,
    ST_PACK,
    ST_LINE_WR,
    ST_DONE
  } state_e;

  typedef enum logic {
    TGT_ROM = 1'b0,
    TGT_NPU = 1'b1
  } tgt_e;

  function automatic int wpl(input int line_w, input int word_w);
    return line_w / word_w;
  endfunction

endpackage

// File: rtl/sys_loader_line_packer.sv
// Assembles WORD_W beats into one LINE_W line, first beat in the LSBs.
// clr has priority over load so an aborted line never leaks into the next one.
module line_packer
  import sys_loader_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              gclk,
  input  logic              grst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [WORD_W-1:0] data,
  output logic [LINE_W-1:0] line,
  output logic              full,
  output logic              last_beat
);

  localparam int WPL = wpl(LINE_W, WORD_W);
  localparam int CW  = (WPL > 1) ? $clog2(WPL) : 1;

  logic [CW-1:0] cnt;

  assign last_beat = (cnt == CW'(WPL - 1));

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      line <= '0;
      cnt  <= '0;
      full <= 1'b0;
    end else if (clr) begin
      line <= '0;
      cnt  <= '0;
      full <= 1'b0;
    end else if (load) begin
      line[cnt*WORD_W +: WORD_W] <= data;
      full <= last_beat;
      cnt  <= last_beat ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sys_loader.sv
// Host-side loader: streams program words into the instruction ROM or packs
// them into NPU RAM lines, holding the CPU and owning the RAM path meanwhile.
module sys_loader
  import sys_loader_pkg::*;
#(
  parameter int WORD_W   = 32,
  parameter int LINE_W   = 256,
  parameter int LINE_CNT = 16,
  parameter int ROM_AW   = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  logic                        cmd_target_i,
  input  logic [ROM_AW-1:0]           cmd_base_i,
  input  logic [ROM_AW-1:0]           cmd_len_i,
  input  logic                        s_valid_i,
  output logic                        s_ready_o,
  input  logic [WORD_W-1:0]           s_data_i,
  input  logic                        s_last_i,
  output logic                        en_w_rom_o,
  output logic [ROM_AW-1:0]           w_rom_addr_o,
  output logic [WORD_W-1:0]           w_rom_data_o,
  output logic                        npu_ram_sel_o,
  output logic                        npu_en_w_o,
  output logic [$clog2(LINE_CNT)-1:0] npu_w_line_o,
  output logic [LINE_W-1:0]           npu_line_data_o,
  output logic                        sys_hold_o,
  output logic                        done_o,
  output logic                        err_o
);

  localparam int LAW = $clog2(LINE_CNT);

  state_e            state, state_nx;
  logic [ROM_AW-1:0] base, len, cnt;   // cnt: words (ROM) or lines (NPU)
  logic [LAW-1:0]    line_idx;
  logic              cmd_acc, beat, final_unit, npu_final, final_beat, bad_last;
  logic [LINE_W-1:0] pk_line;
  logic              pk_full, pk_last_beat, pk_clr, pk_load;

  assign cmd_acc    = cmd_valid_i && cmd_ready_o;
  assign beat       = s_valid_i && s_ready_o;
  assign final_unit = (cnt == len - 1'b1);
  assign npu_final  = pk_last_beat && final_unit;
  assign final_beat = (state == ST_ROM_WR) ? final_unit : npu_final;
  // s_last must coincide exactly with the final beat of the command
  assign bad_last   = final_beat ? !s_last_i : s_last_i;

  assign pk_load = beat && (state == ST_PACK);
  assign pk_clr  = cmd_acc || (pk_load && s_last_i && !npu_final);

  line_packer #(.WORD_W(WORD_W), .LINE_W(LINE_W)) u_packer (
    .gclk      (clk_i),
    .grst_n    (rst_i),
    .clr       (pk_clr),
    .load      (pk_load),
    .data      (s_data_i),
    .line      (pk_line),
    .full      (pk_full),
    .last_beat (pk_last_beat)
  );

  always_comb begin
    state_nx    = state;
    cmd_ready_o = 1'b0;
    s_ready_o   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          if (cmd_len_i == '0)                     state_nx = ST_DONE;
          else if (tgt_e'(cmd_target_i) == TGT_NPU) state_nx = ST_PACK;
          else                                      state_nx = ST_ROM_WR;
        end
      end
      ST_ROM_WR: begin
        s_ready_o = 1'b1;
        if (beat && (s_last_i || final_unit)) state_nx = ST_DONE;
      end
      ST_PACK: begin
        s_ready_o = 1'b1;
        if (beat) begin
          if (s_last_i && !npu_final) state_nx = ST_DONE;
          else if (pk_last_beat)      state_nx = ST_LINE_WR;
        end
      end
      ST_LINE_WR: state_nx = final_unit ? ST_DONE : ST_PACK;
      ST_DONE:    state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state           <= ST_IDLE;
      base            <= '0;
      len             <= '0;
      cnt             <= '0;
      line_idx        <= '0;
      en_w_rom_o      <= 1'b0;
      w_rom_addr_o    <= '0;
      w_rom_data_o    <= '0;
      npu_ram_sel_o   <= 1'b0;
      npu_en_w_o      <= 1'b0;
      npu_w_line_o    <= '0;
      npu_line_data_o <= '0;
      sys_hold_o      <= 1'b0;
      done_o          <= 1'b0;
      err_o           <= 1'b0;
    end else begin
      state         <= state_nx;
      en_w_rom_o    <= 1'b0;
      npu_en_w_o    <= 1'b0;
      done_o        <= (state == ST_DONE);
      npu_ram_sel_o <= (state_nx != ST_IDLE);
      sys_hold_o    <= (state_nx != ST_IDLE);

      if (cmd_acc) begin
        base     <= cmd_base_i;
        len      <= cmd_len_i;
        cnt      <= '0;
        line_idx <= cmd_base_i[LAW-1:0];
        err_o    <= 1'b0;
      end

      if (beat && bad_last) err_o <= 1'b1;

      if (beat && (state == ST_ROM_WR)) begin
        en_w_rom_o   <= 1'b1;
        w_rom_addr_o <= base + cnt;
        w_rom_data_o <= s_data_i;
        cnt          <= cnt + 1'b1;
      end

      // packer still holds the completed line during LINE_WR
      if (state == ST_LINE_WR) begin
        npu_en_w_o      <= pk_full;
        npu_w_line_o    <= line_idx;
        npu_line_data_o <= pk_line;
        cnt             <= cnt + 1'b1;
        line_idx        <= (line_idx == LAW'(LINE_CNT - 1)) ? '0 : line_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sys_loader.sv
// Randomized self-checking bench for sys_loader against a command-level
// reference model of the expected write sequence, error flag and timing.
module tb_sys_loader;

  localparam int WORD_W   = 32;
  localparam int LINE_W   = 256;
  localparam int LINE_CNT = 16;
  localparam int ROM_AW   = 16;
  localparam int WPL      = LINE_W / WORD_W;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cmd_valid = 1'b0, cmd_target = 1'b0;
  logic [ROM_AW-1:0]   cmd_base = '0, cmd_len = '0;
  logic                s_valid = 1'b0, s_last = 1'b0;
  logic [WORD_W-1:0]   s_data = '0;
  logic                cmd_ready_o, s_ready_o, en_w_rom_o, npu_ram_sel_o, npu_en_w_o;
  logic                sys_hold_o, done_o, err_o;
  logic [ROM_AW-1:0]   w_rom_addr_o;
  logic [WORD_W-1:0]   w_rom_data_o;
  logic [3:0]          npu_w_line_o;
  logic [LINE_W-1:0]   npu_line_data_o;

  always #5 clk = ~clk;

  sys_loader #(.WORD_W(WORD_W), .LINE_W(LINE_W), .LINE_CNT(LINE_CNT), .ROM_AW(ROM_AW)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_target_i(cmd_target),
    .cmd_base_i(cmd_base), .cmd_len_i(cmd_len),
    .s_valid_i(s_valid), .s_ready_o(s_ready_o), .s_data_i(s_data), .s_last_i(s_last),
    .en_w_rom_o(en_w_rom_o), .w_rom_addr_o(w_rom_addr_o), .w_rom_data_o(w_rom_data_o),
    .npu_ram_sel_o(npu_ram_sel_o), .npu_en_w_o(npu_en_w_o), .npu_w_line_o(npu_w_line_o),
    .npu_line_data_o(npu_line_data_o), .sys_hold_o(sys_hold_o), .done_o(done_o), .err_o(err_o)
  );

  typedef struct {
    logic [LINE_W-1:0] data;
    int                addr;
    int                cyc;
  } wr_t;

  int  n_chk = 0, n_err = 0, cyc = 0, sel_cnt = 0;
  wr_t rom_q[$], npu_q[$], exp_q[$], obs_q[$];
  int  done_q[$];
  logic [WORD_W-1:0] words[$];
  bit  lasts[$];
  bit  exp_err;
  int  n_use;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (en_w_rom_o) rom_q.push_back('{data: LINE_W'(w_rom_data_o), addr: int'(w_rom_addr_o), cyc: cyc});
    if (npu_en_w_o) npu_q.push_back('{data: npu_line_data_o, addr: int'(npu_w_line_o), cyc: cyc});
    if (done_o) done_q.push_back(cyc);
    if (npu_ram_sel_o) sel_cnt++;
  end

  task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // stream of len units with s_last on the final word; inject flips one last flag
  function automatic void prep(input bit tgt, input int len, input bit inject);
    int total, r;
    total = tgt ? len * WPL : len;
    words.delete(); lasts.delete();
    for (int i = 0; i < total; i++) begin
      words.push_back($urandom);
      lasts.push_back(i == total - 1);
    end
    if (inject && total > 0) begin
      r = $urandom_range(total - 1, 0);
      lasts[r] = !lasts[r];
    end
  endfunction

  // command-level model: which writes happen, how many words get consumed, error flag
  function automatic void model(input bit tgt, input int base, input int len);
    logic [LINE_W-1:0] ln;
    bit stop, fin;
    int i;
    exp_q.delete(); exp_err = 0; n_use = 0; stop = 0;
    if (len == 0) return;
    if (!tgt) begin
      for (int k = 0; k < len; k++) begin
        exp_q.push_back('{data: LINE_W'(words[k]), addr: (base + k) % (1 << ROM_AW), cyc: 0});
        n_use++;
        if (k == len - 1) begin exp_err = !lasts[k]; break; end
        if (lasts[k]) begin exp_err = 1; break; end
      end
    end else begin
      for (int l = 0; l < len && !stop; l++) begin
        ln = '0;
        for (int j = 0; j < WPL; j++) begin
          i   = l * WPL + j;
          fin = (l == len - 1) && (j == WPL - 1);
          ln[j*WORD_W +: WORD_W] = words[i];
          n_use++;
          if (lasts[i] && !fin) begin exp_err = 1; stop = 1; break; end
          if (fin && !lasts[i]) exp_err = 1;
        end
        if (!stop) exp_q.push_back('{data: ln, addr: (base + l) % LINE_CNT, cyc: 0});
      end
    end
  endfunction

  task automatic run_cmd(input bit tgt, input int base, input int len, input bit gaps);
    int acc_cyc, t, first, step;
    bit ok;
    model(tgt, base, len);
    rom_q.delete(); npu_q.delete(); done_q.delete(); sel_cnt = 0;
    cmd_valid = 1; cmd_target = tgt; cmd_base = ROM_AW'(base); cmd_len = ROM_AW'(len);
    s_valid = 1; s_data = 32'hDEAD_BEEF; s_last = 1;   // must not be consumed in IDLE
    chk("cmd_ready", cmd_ready_o, 1);
    chk("s_ready_idle", s_ready_o, 0);
    acc_cyc = cyc;
    @(posedge clk); @(negedge clk);
    cmd_valid = 0; s_valid = 0; s_last = 0;
    chk("err_clr", err_o, 0);
    chk("sel_on", npu_ram_sel_o, 1);
    chk("hold_on", sys_hold_o, 1);
    for (int w = 0; w < n_use; w++) begin
      if (gaps) begin s_valid = 0; @(posedge clk); @(negedge clk); end
      s_valid = 1; s_data = words[w]; s_last = lasts[w];
      ok = 0;
      for (int k = 0; k < 40 && !ok; k++) begin
        ok = s_ready_o;
        @(posedge clk); @(negedge clk);
      end
      if (!ok) begin chk("accept_timeout", ok, 1); break; end
    end
    s_valid = 0; s_last = 0;
    t = 0;
    while (done_q.size() == 0 && t < 40) begin @(negedge clk); t++; end
    chk("done_seen", done_q.size() != 0, 1);
    repeat (2) @(negedge clk);

    chk("done_cnt", done_q.size(), 1);
    chk("err", err_o, exp_err);
    chk("hold_idle", sys_hold_o, 0);
    chk("cmd_ready_idle", cmd_ready_o, 1);
    if (tgt) begin obs_q = npu_q; chk("stray_rom", rom_q.size(), 0); end
    else     begin obs_q = rom_q; chk("stray_npu", npu_q.size(), 0); end
    chk("wr_cnt", obs_q.size(), exp_q.size());
    first = acc_cyc + (tgt ? WPL + 2 : 2);
    step  = tgt ? WPL + 1 : 1;
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      chk("wr_addr", obs_q[k].addr, exp_q[k].addr);
      chk("wr_data", obs_q[k].data, exp_q[k].data);
      if (!gaps) chk("wr_cyc", obs_q[k].cyc, first + k * step);
    end
    if (done_q.size() > 0) begin
      if (len == 0) chk("done_lat0", done_q[0], acc_cyc + 2);
      else if (obs_q.size() > 0) chk("done_after_wr", done_q[0], obs_q[obs_q.size()-1].cyc + 1);
      chk("sel_cycles", sel_cnt, done_q[0] - acc_cyc - 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit tgt, gaps, inj;
    int base, len;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready_o, 1);
    chk("rst_s_ready", s_ready_o, 0);
    chk("rst_outs", {en_w_rom_o, npu_en_w_o, npu_ram_sel_o, sys_hold_o, done_o, err_o}, 0);
    chk("rst_buses", {w_rom_addr_o, w_rom_data_o, npu_w_line_o, npu_line_data_o}, 0);
    rst_n = 1;
    @(negedge clk);

    // ROM load 0x10..0x13
    prep(0, 4, 0);
    for (int k = 0; k < 4; k++) words[k] = 32'hA0 + k;
    run_cmd(0, 16'h0010, 4, 0);

    // NPU load with line wrap 15 -> 0
    prep(1, 2, 0);
    for (int k = 0; k < 2 * WPL; k++) words[k] = k;
    run_cmd(1, 15, 2, 0);
    if (npu_q.size() == 2) chk("line0_word0", npu_q[1].data[WORD_W-1:0], 8);
    else chk("line0_present", npu_q.size(), 2);

    // early s_last on beat 5 of an NPU line
    prep(1, 1, 0);
    lasts[WPL-1] = 0; lasts[5] = 1;
    run_cmd(1, 4, 1, 0);

    // zero-length command; also clears the sticky error
    prep(0, 0, 0);
    run_cmd(0, 5, 0, 0);

    // reset during beat 3 of an NPU line
    prep(1, 1, 0);
    cmd_valid = 1; cmd_target = 1; cmd_base = 3; cmd_len = 1;
    @(posedge clk); @(negedge clk);
    cmd_valid = 0;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1; s_data = words[k]; s_last = 0;
      @(posedge clk); @(negedge clk);
    end
    s_data = words[3];
    #2 rst_n = 0;
    #1;
    chk("arst_outs", {en_w_rom_o, npu_en_w_o, npu_ram_sel_o, sys_hold_o, done_o, err_o, s_ready_o}, 0);
    chk("arst_buses", {w_rom_addr_o, w_rom_data_o, npu_w_line_o, npu_line_data_o}, 0);
    @(negedge clk);
    s_valid = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("arst_cmd_ready", cmd_ready_o, 1);
    prep(1, 1, 0);
    run_cmd(1, 7, 1, 0);

    // ROM load with a gapped stream
    prep(0, 6, 0);
    run_cmd(0, 16'h0200, 6, 1);

    for (int it = 0; it < 24; it++) begin
      tgt  = 1'($urandom_range(1, 0));
      gaps = 1'($urandom_range(1, 0));
      inj  = ($urandom_range(3, 0) == 0);
      if (tgt) begin
        base = $urandom_range(LINE_CNT - 1, 0);
        len  = $urandom_range(3, 1);
      end else begin
        base = $urandom_range(1, 0) ? $urandom_range(65535, 65530) : $urandom_range(4095, 0);
        len  = $urandom_range(9, 1);
      end
      prep(tgt, len, inj);
      run_cmd(tgt, base, len, gaps);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
